// File: rtl/muldiv_unit_pkg.sv
// Op and state encodings shared by the MIPS32 multiply/divide engine and its bench.
// Pure declarations; no latency or flow control of its own.
package muldiv_unit_pkg;

  localparam int DATALENGTH = 32;

  localparam logic [2:0] MULDIV_OP_MULT  = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'b001;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'b010;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_MADD  = 3'b100;
  localparam logic [2:0] MULDIV_OP_MADDU = 3'b101;
  localparam logic [2:0] MULDIV_OP_MSUB  = 3'b110;
  localparam logic [2:0] MULDIV_OP_MSUBU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV) ||
           (op == MULDIV_OP_MADD) || (op == MULDIV_OP_MSUB);
  endfunction

  function automatic logic op_is_mac(input logic [2:0] op);
    return (op == MULDIV_OP_MADD) || (op == MULDIV_OP_MADDU) ||
           (op == MULDIV_OP_MSUB) || (op == MULDIV_OP_MSUBU);
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == MULDIV_OP_MSUB) || (op == MULDIV_OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/result bundle between the issue logic (master) and muldiv_unit (slave).
// No state; issue logic stalls HI/LO readers on start || busy.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic                  start;
  logic [2:0]            op;
  logic [DATALENGTH-1:0] src_a;
  logic [DATALENGTH-1:0] src_b;
  logic [DATALENGTH-1:0] hi_acc;
  logic [DATALENGTH-1:0] lo_acc;
  logic                  cancel;
  logic                  busy;
  logic                  writeHi;
  logic                  writeLo;
  logic [DATALENGTH-1:0] hi_data_out;
  logic [DATALENGTH-1:0] lo_data_out;

  modport master (
    output start, op, src_a, src_b, hi_acc, lo_acc, cancel,
    input  busy, writeHi, writeLo, hi_data_out, lo_data_out
  );

  modport slave (
    input  start, op, src_a, src_b, hi_acc, lo_acc, cancel,
    output busy, writeHi, writeLo, hi_data_out, lo_data_out
  );

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
// Latency DIV_ITERS steps after load; advances only while step is high, done flags the final step.
module muldiv_unit_div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATALENGTH-1:0] dividend,
  input  logic [DATALENGTH-1:0] divisor,
  output logic                  done,
  output logic [DATALENGTH-1:0] quotient,
  output logic [DATALENGTH-1:0] remainder
);

  localparam int CW = $clog2(DIV_ITERS + 1);

  logic [DATALENGTH-1:0] rem_q;
  logic [DATALENGTH-1:0] quo_q;
  logic [DATALENGTH-1:0] dvs_q;
  logic [CW-1:0]         cnt_q;
  logic [DATALENGTH:0]   partial;
  logic [DATALENGTH:0]   trial;

  // quotient/remainder are the values this step will commit, so the parent
  // can capture the final result on the same edge the last bit lands.
  always_comb begin
    partial   = {rem_q, quo_q[DATALENGTH-1]};
    trial     = partial - {1'b0, dvs_q};
    remainder = partial[DATALENGTH-1:0];
    quotient  = {quo_q[DATALENGTH-2:0], 1'b0};
    if (!trial[DATALENGTH]) begin
      remainder = trial[DATALENGTH-1:0];
      quotient  = {quo_q[DATALENGTH-2:0], 1'b1};
    end
  end

  assign done = step && (cnt_q == CW'(DIV_ITERS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS32 HI/LO multiply/divide engine; strobes at T+2 (mul), T+33 (div), T+1 (div by zero).
// One op at a time: start ignored while busy; cancel aborts silently. MULDIV_MADD_EN enables MADD/MSUB.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  state_t                state_q, state_d;
  logic [2:0]            op_q;
  logic [DATALENGTH-1:0] a_q, b_q;
  logic                  quo_neg_q, rem_neg_q;
  logic [63:0]           res_q;

  logic                  div_load, div_step, div_done;
  logic [DATALENGTH-1:0] div_quo, div_rem;

  logic                  in_signed;
  logic [DATALENGTH-1:0] a_mag, b_mag;
  logic [63:0]           a_ext, b_ext, product, mul_result;
  logic [DATALENGTH-1:0] quo_fix, rem_fix;

  assign in_signed = op_is_signed(bus.op);
  assign a_mag     = (in_signed && bus.src_a[DATALENGTH-1]) ? -bus.src_a : bus.src_a;
  assign b_mag     = (in_signed && bus.src_b[DATALENGTH-1]) ? -bus.src_b : bus.src_b;

  // Mod-2^64 product of sign/zero-extended operands equals the signed product.
  assign a_ext   = op_is_signed(op_q) ? {{32{a_q[DATALENGTH-1]}}, a_q} : {32'd0, a_q};
  assign b_ext   = op_is_signed(op_q) ? {{32{b_q[DATALENGTH-1]}}, b_q} : {32'd0, b_q};
  assign product = a_ext * b_ext;

`ifdef MULDIV_MADD_EN
  logic [63:0] acc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else if (state_q == ST_IDLE && bus.start && !bus.cancel) begin
      acc_q <= {bus.hi_acc, bus.lo_acc};
    end
  end

  assign mul_result = !op_is_mac(op_q) ? product :
                      op_is_sub(op_q)  ? acc_q - product : acc_q + product;
`else
  logic unused_acc;
  assign unused_acc = ^{bus.hi_acc, bus.lo_acc};
  assign mul_result = product;
`endif

  assign quo_fix = quo_neg_q ? -div_quo : div_quo;
  assign rem_fix = rem_neg_q ? -div_rem : div_rem;

  muldiv_unit_div_iter #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div_iter (
    .clock     (clock),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (!op_is_div(bus.op)) begin
            state_d = ST_MUL;
          end else if (bus.src_b == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_DIV;
            div_load = 1'b1;
          end
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV: begin
        div_step = 1'b1;
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.cancel) begin
      state_d  = ST_IDLE;
      div_load = 1'b0;
      div_step = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      res_q     <= '0;
    end else if (!bus.cancel) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            a_q       <= bus.src_a;
            b_q       <= bus.src_b;
            quo_neg_q <= in_signed && (bus.src_a[DATALENGTH-1] ^ bus.src_b[DATALENGTH-1]);
            rem_neg_q <= in_signed && bus.src_a[DATALENGTH-1];
            if (op_is_div(bus.op) && bus.src_b == '0) begin
              res_q <= {bus.src_a, {DATALENGTH{1'b1}}};
            end
          end
        end
        ST_MUL: res_q <= mul_result;
        ST_DIV: begin
          if (div_done) res_q <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.writeHi     = (state_q == ST_DONE) && !bus.cancel;
  assign bus.writeLo     = (state_q == ST_DONE) && !bus.cancel;
  assign bus.hi_data_out = res_q[63:32];
  assign bus.lo_data_out = res_q[31:0];

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, HI/LO results, cancel, reset and ignored starts.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  muldiv_unit_if bus ();

  muldiv_unit #(
    .DIV_ITERS (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hacc, input logic [31:0] lacc);
    bus.op     = op;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.hi_acc = hacc;
    bus.lo_acc = lacc;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hacc, input logic [31:0] lacc,
                        input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    check_eq({tag, " busy@T"}, 64'(bus.busy), 64'd0);
    issue(op, a, b, hacc, lacc);
    check_eq({tag, " busy@T+1"}, 64'(bus.busy), 64'd1);
    lat = 1;
    while (!bus.writeHi && lat < 100) begin
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " hi"}, 64'(bus.hi_data_out), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(bus.lo_data_out), 64'(exp_lo));
    check_eq({tag, " writeLo"}, 64'(bus.writeLo), 64'd1);
    tick();
    check_eq({tag, " idle after"}, 64'({bus.busy, bus.writeHi}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.hi_acc = '0;
    bus.lo_acc = '0;
    bus.cancel = 1'b0;
    tick();
    tick();
    check_eq("reset busy", 64'(bus.busy), 64'd0);
    check_eq("reset strobes", 64'({bus.writeHi, bus.writeLo}), 64'd0);
    check_eq("reset data", {bus.hi_data_out, bus.lo_data_out}, 64'd0);
    reset = 1'b0;
    tick();

    // Back-to-back: each run_op issues in the first idle cycle after the previous DONE.
    run_op("mult",    MULDIV_OP_MULT,  32'hFFFF_FFFE, 32'd3, '0, '0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",   MULDIV_OP_MULTU, 32'hFFFF_FFFE, 32'd3, '0, '0, 2, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div -7/2", MULDIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, '0, '0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", MULDIV_OP_DIV,  32'd7, 32'hFFFF_FFFE, '0, '0, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("divu 100/7", MULDIV_OP_DIVU, 32'd100, 32'd7, '0, '0, 33, 32'd2, 32'd14);
    run_op("div min/-1", MULDIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, 33, 32'd0, 32'h8000_0000);
    run_op("divu 5/0", MULDIV_OP_DIVU, 32'd5, 32'd0, '0, '0, 1, 32'd5, 32'hFFFF_FFFF);
    run_op("div neg/0", MULDIV_OP_DIV, 32'hFFFF_FFF0, 32'd0, '0, '0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

`ifdef MULDIV_MADD_EN
    run_op("madd", MULDIV_OP_MADD, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFF, 2, 32'd1, 32'd5);
    run_op("msubu", MULDIV_OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    run_op("op100 as mult", MULDIV_OP_MADD, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFF, 2, 32'd0, 32'd6);
    run_op("op111 as multu", MULDIV_OP_MSUBU, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           2, 32'd2, 32'hFFFF_FFFA);
`endif

    // Cancel in the middle of a divide.
    issue(MULDIV_OP_DIVU, 32'd100, 32'd7, '0, '0);
    strobes = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (bus.writeHi || bus.writeLo) strobes++;
    end
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check_eq("cancel busy@T+11", 64'(bus.busy), 64'd0);
    if (bus.writeHi || bus.writeLo) strobes++;
    check_eq("cancel no strobe", 64'(strobes), 64'd0);
    run_op("after cancel", MULDIV_OP_DIVU, 32'd100, 32'd7, '0, '0, 33, 32'd2, 32'd14);

    // Cancel during DONE masks the strobes in the same cycle.
    issue(MULDIV_OP_MULT, 32'd2, 32'd3, '0, '0);
    tick();
    bus.cancel = 1'b1;
    #1;
    check_eq("cancel done strobes", 64'({bus.writeHi, bus.writeLo}), 64'd0);
    tick();
    bus.cancel = 1'b0;
    check_eq("cancel done busy", 64'(bus.busy), 64'd0);

    // Reset mid-divide clears everything on the next edge.
    issue(MULDIV_OP_DIVU, 32'd100, 32'd7, '0, '0);
    for (int c = 2; c <= 5; c++) tick();
    reset = 1'b1;
    tick();
    check_eq("reset mid busy", 64'(bus.busy), 64'd0);
    check_eq("reset mid strobes", 64'({bus.writeHi, bus.writeLo}), 64'd0);
    check_eq("reset mid data", {bus.hi_data_out, bus.lo_data_out}, 64'd0);
    reset = 1'b0;
    tick();

    // A start raised while the multiply is in flight must not be taken.
    issue(MULDIV_OP_MULT, 32'd7, 32'd6, '0, '0);
    bus.op    = MULDIV_OP_DIVU;
    bus.src_a = 32'd9;
    bus.src_b = 32'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("busy start strobe", 64'(bus.writeHi), 64'd1);
    check_eq("busy start data", {bus.hi_data_out, bus.lo_data_out}, 64'd42);
    tick();
    check_eq("busy start idle T+3", 64'(bus.busy), 64'd0);
    tick();
    check_eq("busy start idle T+4", 64'({bus.busy, bus.writeHi}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
